// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Physical-register free list for the rename stage. Hands out up to
//   FETCH_WIDTH fresh pdsts per cycle from a speculative head pointer, takes
//   back the previous mappings of committing instructions at the tail, and
//   snaps the speculative head back to the committed head on a flush.
//
//   The ring holds DEPTH = NUM_PREG - NUM_AREG ids. Pointers carry one extra
//   wrap bit so that a full list (tail - head == DEPTH) differs from an
//   empty one (tail == head).
//
// Ports
//   clk             clock
//   resetn          asynchronous active-low reset
//   alloc_valid     rename holds a bundle that needs pdsts
//   alloc_req       per-slot request (slot writes a non-x0 destination)
//   alloc_ready     list can satisfy any bundle this cycle
//   alloc_id        per-slot allocated preg id (0 for non-requesting slots)
//   commit_valid    per-slot: committing instruction has a non-x0 destination
//   commit_free_id  per-slot old preg released by that commit
//   flush           squash all speculative allocations
//   free_count      registered number of free entries (tail - head)
// -----------------------------------------------------------------------------
module free_list #(
  parameter int FETCH_WIDTH = 2,
  parameter int NUM_PREG    = 64,
  parameter int NUM_AREG    = 32
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            alloc_valid,
  input  logic [FETCH_WIDTH-1:0]          alloc_req,
  output logic                            alloc_ready,
  output logic [FETCH_WIDTH*$clog2(NUM_PREG)-1:0] alloc_id,
  input  logic [FETCH_WIDTH-1:0]          commit_valid,
  input  logic [FETCH_WIDTH*$clog2(NUM_PREG)-1:0] commit_free_id,
  input  logic                            flush,
  output logic [$clog2(NUM_PREG):0]       free_count
);

  localparam int PW    = $clog2(NUM_PREG);
  localparam int DEPTH = NUM_PREG - NUM_AREG;
  localparam int IW    = $clog2(DEPTH);
  localparam int PTRW  = IW + 1;

  logic [PW-1:0]   r_mem [DEPTH];
  logic [PTRW-1:0] r_head;       // speculative allocation pointer
  logic [PTRW-1:0] r_arch_head;  // allocation pointer as seen by committed state
  logic [PTRW-1:0] r_tail;       // next slot to receive a released id

  logic [PTRW-1:0] w_alloc_n;
  logic [PTRW-1:0] w_rel_m;
  logic [IW-1:0]   w_wr_idx [FETCH_WIDTH];
  logic [PTRW-1:0] w_head_nxt;
  logic [PTRW-1:0] w_arch_head_nxt;
  logic [PTRW-1:0] w_tail_nxt;
  logic [PTRW-1:0] w_used;
  logic            w_fire;

  assign w_used      = r_tail - r_head;
  assign free_count  = (PW+1)'(w_used);
  // Readiness ignores how many slots actually request, so rename only ever
  // stalls whole bundles.
  assign alloc_ready = (free_count >= (PW+1)'(FETCH_WIDTH)) && !flush;
  assign w_fire      = alloc_valid && alloc_ready;

  // Allocation: requesting slot k takes the entry at head + (number of
  // requesting slots below k), so ids are packed with no holes.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment; otherwise synthesis infers a latch for the untaken paths.
  always_comb begin
    logic [PTRW-1:0] v_cnt;
    logic [PTRW-1:0] v_ptr;
    v_cnt    = '0;
    v_ptr    = '0;
    alloc_id = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      v_ptr = r_head + v_cnt;
      if (alloc_req[k]) begin
        alloc_id[k*PW +: PW] = r_mem[v_ptr[IW-1:0]];
      end
      v_cnt = v_cnt + PTRW'(alloc_req[k]);
    end
    w_alloc_n = v_cnt;
  end

  // Release: committing slots write at tail, tail+1, ... in slot order.
  always_comb begin
    logic [PTRW-1:0] v_cnt;
    logic [PTRW-1:0] v_ptr;
    v_cnt = '0;
    v_ptr = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      v_ptr       = r_tail + v_cnt;
      w_wr_idx[k] = v_ptr[IW-1:0];
      v_cnt       = v_cnt + PTRW'(commit_valid[k]);
    end
    w_rel_m = v_cnt;
  end

  // Each committing dst-writer consumed exactly one entry in program order,
  // so the committed head advances by the release count. A flush restores
  // the speculative head to it, this cycle's commits included.
  always_comb begin
    w_arch_head_nxt = r_arch_head + w_rel_m;
    w_tail_nxt      = r_tail + w_rel_m;
    w_head_nxt      = r_head;
    if (flush) begin
      w_head_nxt = w_arch_head_nxt;
    end else if (w_fire) begin
      w_head_nxt = r_head + w_alloc_n;
    end
  end

  // NOTE: the id storage is reset along with the pointers on purpose: after
  // reset the ring must already hold the ids NUM_AREG..NUM_PREG-1, so it is
  // built from resettable flops rather than an uninitialised RAM.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= PW'(NUM_AREG + i);
      end
      r_head      <= '0;
      r_arch_head <= '0;
      r_tail      <= PTRW'(DEPTH);
    end else begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (commit_valid[k]) begin
          r_mem[w_wr_idx[k]] <= commit_free_id[k*PW +: PW];
        end
      end
      r_head      <= w_head_nxt;
      r_arch_head <= w_arch_head_nxt;
      r_tail      <= w_tail_nxt;
    end
  end

  // Protocol checks (simulation only; the list does not recover from these).
  a_no_overfill: assert property (@(posedge clk) disable iff (!resetn)
    (w_tail_nxt - w_head_nxt) <= PTRW'(DEPTH))
    else $error("free_list: release would exceed DEPTH free entries");

  a_req_stable: assert property (@(posedge clk) disable iff (!resetn)
    (alloc_valid && !alloc_ready && !flush) |=> $stable(alloc_req))
    else $error("free_list: alloc_req changed while stalled");

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_chk
    a_no_p0: assert property (@(posedge clk) disable iff (!resetn)
      commit_valid[g] |-> (commit_free_id[g*PW +: PW] != '0))
      else $error("free_list: p0 released on slot %0d", g);
  end

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
//   Directed scenarios followed by a randomized phase. The reference model is
//   an unbounded, append-only log of ids (initial ids then every released id
//   in release order) with two integer positions: the speculative and the
//   committed allocation points. Free entries are simply log size minus the
//   speculative position; there is no ring, no wrap bit.
// -----------------------------------------------------------------------------
module tb_free_list;

  localparam int FW    = 2;
  localparam int PW    = 6;
  localparam int DEPTH = 32;

  logic            clk            = 1'b0;
  logic            resetn         = 1'b1;
  logic            alloc_valid    = 1'b0;
  logic [FW-1:0]   alloc_req      = '0;
  logic            alloc_ready;
  logic [FW*PW-1:0] alloc_id;
  logic [FW-1:0]   commit_valid   = '0;
  logic [FW*PW-1:0] commit_free_id = '0;
  logic            flush          = 1'b0;
  logic [PW:0]     free_count;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model state.
  int log_q[$];
  int spec_pos;
  int arch_pos;
  bit exp_ready;
  bit hold;

  always #5 clk = ~clk;

  free_list dut (
    .clk            (clk),
    .resetn         (resetn),
    .alloc_valid    (alloc_valid),
    .alloc_req      (alloc_req),
    .alloc_ready    (alloc_ready),
    .alloc_id       (alloc_id),
    .commit_valid   (commit_valid),
    .commit_free_id (commit_free_id),
    .flush          (flush),
    .free_count     (free_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    log_q.delete();
    for (int i = 0; i < DEPTH; i++) log_q.push_back(32 + i);
    spec_pos = 0;
    arch_pos = 0;
    hold     = 1'b0;
  endtask

  // Compare the combinational outputs with the model for the current inputs.
  task automatic model_check();
    int free;
    int cnt;
    free = log_q.size() - spec_pos;
    cnt  = 0;
    exp_ready = (free >= FW) && !flush;
    check("free_count", 32'(free_count), free);
    check("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
    for (int k = 0; k < FW; k++) begin
      if (!alloc_req[k]) begin
        check($sformatf("alloc_id%0d_idle", k), 32'(alloc_id[k*PW +: PW]), 0);
      end else if (spec_pos + cnt < log_q.size()) begin
        check($sformatf("alloc_id%0d", k), 32'(alloc_id[k*PW +: PW]), log_q[spec_pos + cnt]);
      end
      cnt += int'(alloc_req[k]);
    end
  endtask

  // Drive inputs just after a rising edge, then check at the falling edge.
  task automatic apply(input logic v, input logic [FW-1:0] req, input logic [FW-1:0] cv,
                       input logic [PW-1:0] c0, input logic [PW-1:0] c1, input logic fl);
    alloc_valid    = v;
    alloc_req      = req;
    commit_valid   = cv;
    commit_free_id = {c1, c0};
    flush          = fl;
    @(negedge clk);
    model_check();
  endtask

  // Advance one clock and apply the same transaction to the model.
  task automatic tick();
    int m;
    m = 0;
    @(posedge clk);
    for (int k = 0; k < FW; k++) begin
      if (commit_valid[k]) begin
        log_q.push_back(int'(commit_free_id[k*PW +: PW]));
        m++;
      end
    end
    arch_pos += m;
    if (flush) spec_pos = arch_pos;
    else if (alloc_valid && exp_ready) spec_pos += $countones(alloc_req);
    hold = alloc_valid && !exp_ready && !flush;
    #1;
  endtask

  task automatic do_reset();
    resetn         = 1'b0;
    alloc_valid    = 1'b0;
    alloc_req      = '0;
    commit_valid   = '0;
    commit_free_id = '0;
    flush          = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    logic          v;
    logic [FW-1:0] req;
    logic [FW-1:0] cv;
    logic [PW-1:0] c0;
    logic [PW-1:0] c1;
    logic          fl;
    int            outst;

    #2;
    // Two-wide allocations from reset.
    do_reset();
    apply(1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    check("rst_free_count", 32'(free_count), 32);
    check("rst_ready", 32'(alloc_ready), 1);
    tick();
    apply(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
    check("a1_id0", 32'(alloc_id[5:0]), 32);
    check("a1_id1", 32'(alloc_id[11:6]), 33);
    tick();
    apply(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
    check("a2_id0", 32'(alloc_id[5:0]), 34);
    check("a2_id1", 32'(alloc_id[11:6]), 35);
    check("a2_fc", 32'(free_count), 30);
    tick();
    apply(1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    check("a3_fc", 32'(free_count), 28);
    tick();

    // Sparse requests pack ids with no holes.
    do_reset();
    apply(1'b1, 2'b10, 2'b00, 0, 0, 1'b0);
    check("sp_id1", 32'(alloc_id[11:6]), 32);
    check("sp_id0", 32'(alloc_id[5:0]), 0);
    tick();
    apply(1'b1, 2'b01, 2'b00, 0, 0, 1'b0);
    check("sp_fc", 32'(free_count), 31);
    check("sp2_id0", 32'(alloc_id[5:0]), 33);
    tick();

    // Drain to empty, then refill one entry at a time across the wrap.
    do_reset();
    repeat (16) begin
      apply(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
      tick();
    end
    apply(1'b1, 2'b11, 2'b01, 5, 0, 1'b0);
    check("full_fc", 32'(free_count), 0);
    check("full_ready", 32'(alloc_ready), 0);
    tick();
    apply(1'b1, 2'b11, 2'b01, 7, 0, 1'b0);
    check("one_fc", 32'(free_count), 1);
    check("one_ready", 32'(alloc_ready), 0);
    tick();
    apply(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
    check("wrap_ready", 32'(alloc_ready), 1);
    check("wrap_id0", 32'(alloc_id[5:0]), 5);
    check("wrap_id1", 32'(alloc_id[11:6]), 7);
    tick();

    // Flush with same-cycle commits.
    do_reset();
    repeat (3) begin
      apply(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
      tick();
    end
    apply(1'b1, 2'b11, 2'b11, 8, 9, 1'b1);
    check("fl_ready", 32'(alloc_ready), 0);
    tick();
    apply(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
    check("fl_fc", 32'(free_count), 32);
    check("fl_id0", 32'(alloc_id[5:0]), 34);
    check("fl_id1", 32'(alloc_id[11:6]), 35);
    tick();

    // Flush with no commits returns to the initial mapping.
    do_reset();
    repeat (2) begin
      apply(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
      tick();
    end
    apply(1'b1, 2'b11, 2'b00, 0, 0, 1'b1);
    check("fl2_ready", 32'(alloc_ready), 0);
    tick();
    apply(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
    check("fl2_fc", 32'(free_count), 32);
    check("fl2_id0", 32'(alloc_id[5:0]), 32);
    check("fl2_id1", 32'(alloc_id[11:6]), 33);
    tick();

    // Asynchronous reset in the middle of a cycle.
    do_reset();
    repeat (5) begin
      apply(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
      tick();
    end
    apply(1'b0, 2'b00, 2'b11, 3, 4, 1'b0);
    tick();
    apply(1'b0, 2'b00, 2'b01, 6, 0, 1'b0);
    tick();
    check("pre_ar_fc", 32'(free_count), 25);
    #2;
    resetn      = 1'b0;
    alloc_valid = 1'b0;
    alloc_req   = 2'b11;
    commit_valid = '0;
    flush       = 1'b0;
    #1;
    check("ar_fc", 32'(free_count), 32);
    check("ar_ready", 32'(alloc_ready), 1);
    check("ar_id0", 32'(alloc_id[5:0]), 32);
    check("ar_id1", 32'(alloc_id[11:6]), 33);
    model_reset();
    @(posedge clk);
    #1 resetn = 1'b1;
    apply(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
    check("ar2_id0", 32'(alloc_id[5:0]), 32);
    check("ar2_id1", 32'(alloc_id[11:6]), 33);
    tick();

    // Randomized traffic against the log model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v     = ($urandom_range(9, 0) < 7);
      req   = hold ? alloc_req : FW'($urandom_range(3, 0));
      fl    = ($urandom_range(24, 0) == 0);
      outst = spec_pos - arch_pos;
      cv    = FW'($urandom_range(3, 0));
      if (outst == 0) cv = 2'b00;
      else if (outst == 1 && cv == 2'b11) cv = 2'b10;
      c0    = PW'($urandom_range(63, 1));
      c1    = PW'($urandom_range(63, 1));
      apply(v, req, cv, c0, c1, fl);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
